// File: rtl/rv32i_pkg.sv
// Shared rv32i_seg definitions: ALU op codes, opcodes,
// funct7 constants and operand-select encodings.
package rv32i_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b1000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SRA   = 4'b1101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_PASSB = 4'b1001
  } alu_op_t;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    A_ZERO = 2'd0,
    A_RS1  = 2'd1,
    A_PC   = 2'd2
  } a_sel_t;

  typedef enum logic [1:0] {
    B_ZERO = 2'd0,
    B_RS2  = 2'd1,
    B_IMM  = 2'd2
  } b_sel_t;

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational RV32I decoder: instr -> alu_op, operand selects,
// immediate, reg_write, alu_used, illegal.
module alu_issue_dec
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_t     alu_op,
  output a_sel_t      a_sel,
  output b_sel_t      b_sel,
  output logic [31:0] imm,
  output logic        reg_write,
  output logic        alu_used,
  output logic        illegal
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u = {instr[31:12], 12'b0};
  assign shamt = {27'b0, instr[24:20]};

  always_comb begin
    alu_op    = ALU_ADD;
    a_sel     = A_ZERO;
    b_sel     = B_ZERO;
    imm       = '0;
    reg_write = 1'b0;
    alu_used  = 1'b0;
    illegal   = 1'b0;
    unique case (opc)
      OP: begin
        a_sel     = A_RS1;
        b_sel     = B_RS2;
        alu_used  = 1'b1;
        reg_write = 1'b1;
        alu_op    = alu_op_t'({f7[5], f3});
        if (!(f7 == F7_BASE ||
              (f7 == F7_ALT &&
               (f3 == 3'b000 || f3 == 3'b101))))
          illegal = 1'b1;
      end
      OP_IMM: begin
        a_sel     = A_RS1;
        b_sel     = B_IMM;
        alu_used  = 1'b1;
        reg_write = 1'b1;
        imm       = imm_i;
        alu_op    = alu_op_t'({1'b0, f3});
        if (f3 == 3'b001) begin
          imm = shamt;
          if (f7 != F7_BASE) illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          imm    = shamt;
          alu_op = alu_op_t'({f7[5], f3});
          if (f7 != F7_BASE && f7 != F7_ALT)
            illegal = 1'b1;
        end
      end
      LUI: begin
        b_sel     = B_IMM;
        imm       = imm_u;
        alu_op    = ALU_PASSB;
        alu_used  = 1'b1;
        reg_write = 1'b1;
      end
      AUIPC: begin
        a_sel     = A_PC;
        b_sel     = B_IMM;
        imm       = imm_u;
        alu_used  = 1'b1;
        reg_write = 1'b1;
      end
      LOAD: begin
        a_sel     = A_RS1;
        b_sel     = B_IMM;
        imm       = imm_i;
        alu_used  = 1'b1;
        reg_write = 1'b1;
      end
      STORE: begin
        a_sel    = A_RS1;
        b_sel    = B_IMM;
        imm      = imm_s;
        alu_used = 1'b1;
      end
      JAL, JALR: reg_write = 1'b1;
      BRANCH, FENCE, SYSTEM: ;
      default: illegal = 1'b1;
    endcase
    // Malformed encodings issue as an inert bubble-like op.
    if (illegal) begin
      alu_op    = ALU_ADD;
      a_sel     = A_ZERO;
      b_sel     = B_ZERO;
      reg_write = 1'b0;
      alu_used  = 1'b0;
    end
    if (instr[11:7] == 5'd0) reg_write = 1'b0;
  end

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: decode, operand select, valid/ready register.
// ALU_ISSUE_FWD_EN adds ex_fwd_wr/ex_fwd_rd/ex_fwd_res forwarding.
module alu_issue
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
`ifdef ALU_ISSUE_FWD_EN
  input  logic            ex_fwd_wr,
  input  logic [4:0]      ex_fwd_rd,
  input  logic [XLEN-1:0] ex_fwd_res,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            alu_used,
  output logic            illegal
);

  alu_op_t         d_op;
  a_sel_t          d_a_sel;
  b_sel_t          d_b_sel;
  logic [31:0]     d_imm;
  logic            d_wr;
  logic            d_used;
  logic            d_ill;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [XLEN-1:0] a_nxt;
  logic [XLEN-1:0] b_nxt;
  logic            accept;

  alu_issue_dec u_dec (
    .instr     (instr),
    .alu_op    (d_op),
    .a_sel     (d_a_sel),
    .b_sel     (d_b_sel),
    .imm       (d_imm),
    .reg_write (d_wr),
    .alu_used  (d_used),
    .illegal   (d_ill)
  );

`ifdef ALU_ISSUE_FWD_EN
  assign src1 = (ex_fwd_wr && ex_fwd_rd != 5'd0 &&
                 ex_fwd_rd == instr[19:15]) ?
                ex_fwd_res : rs1_data;
  assign src2 = (ex_fwd_wr && ex_fwd_rd != 5'd0 &&
                 ex_fwd_rd == instr[24:20]) ?
                ex_fwd_res : rs2_data;
`else
  assign src1 = rs1_data;
  assign src2 = rs2_data;
`endif

  always_comb begin
    a_nxt = '0;
    unique case (d_a_sel)
      A_RS1:   a_nxt = src1;
      A_PC:    a_nxt = pc;
      default: a_nxt = '0;
    endcase
  end

  always_comb begin
    b_nxt = '0;
    unique case (d_b_sel)
      B_RS2:   b_nxt = src2;
      B_IMM:   b_nxt = d_imm;
      default: b_nxt = '0;
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 4'b0000;
      rd        <= 5'd0;
      reg_write <= 1'b0;
      alu_used  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (accept && !flush) begin
        alu_a     <= a_nxt;
        alu_b     <= b_nxt;
        alu_op    <= d_op;
        rd        <= instr[11:7];
        reg_write <= d_wr;
        alu_used  <= d_used;
        illegal   <= d_ill;
      end
    end
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-to-execute issue stage for the rv32i_seg pipeline. It accepts one instruction per handshake from decode, along with its register-file operands. It produces the 4-bit ALU operation code, both ALU operands, and the writeback controls. All outputs sit in an ID/EX pipeline register with valid/ready flow control and flush. This block is the producer end of the ALU op/operand interface; the EX stage feeds its outputs straight into the ALU.

## Interface
Parameters:
- XLEN, 32, datapath width (only 32 supported)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- instr  in  32  raw RV32I instruction
- pc  in  32  instruction address
- rs1_data  in  32  register file read port 1
- rs2_data  in  32  register file read port 2
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  EX accepts this cycle
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_op  out  4  ALU operation code
- rd  out  5  destination register
- reg_write  out  1  write rd at writeback (0 when rd==0)
- alu_used  out  1  instruction is ALU class
- illegal  out  1  unknown/malformed encoding
- ex_fwd_wr, ex_fwd_rd[4:0], ex_fwd_res[31:0]  in  forwarding inputs (present only with the macro)

## Operation
- ALU op codes:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011
  - XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, PASSB 1001
  - The code is {funct7[5], funct3} for R-type.
- OP (0110011):
  - A=rs1, B=rs2.
  - funct7 must be 0000000 or 0100000; 0100000 is legal only with funct3 000 or 101. Anything else sets illegal.
- OP-IMM (0010011):
  - A=rs1, B=sign-extended instr[31:20].
  - funct3 000 is always ADD.
  - Shifts: B={27'b0, instr[24:20]}. funct7 0100000 is legal only for 101 (SRA); funct7 0000000 is legal for both shifts. Anything else sets illegal.
  - SLTIU compares against the sign-extended immediate using SLTU.
- LUI (0110111): B={instr[31:12],12'b0}, op PASSB, A=0.
- AUIPC (0010111): A=pc, B=U-immediate, op ADD.
- LOAD (0000011) / STORE (0100011): ADD, A=rs1, B=I- or S-immediate. reg_write is set for loads only.
- BRANCH, JAL, JALR, FENCE, SYSTEM: alu_used=0, op ADD, A=B=0, reg_write=1 only for JAL/JALR.
- Any other opcode: illegal=1, reg_write=0, alu_used=0. The instruction still issues.
- reg_write is forced to 0 when rd==0.

## Timing
- Latency is 1 cycle: input accepted at edge N is visible on the outputs after edge N.
- in_ready = !out_valid || out_ready (combinational, no bubble on steady flow).
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Outputs are stable while out_valid && !out_ready.
- Accept without transfer out: register loads and out_valid=1. Transfer out without accept: out_valid=0.
- Accept and transfer out in the same cycle: register reloads and out_valid stays 1.
- flush=1 at an edge forces out_valid=0 and discards any simultaneous accept. in_ready is unaffected by flush.
- Reset (rst_n low at an edge, also mid-transfer):
  - out_valid=0, alu_op=0000, alu_a=alu_b=0, rd=0.
  - reg_write=alu_used=illegal=0.
  - Reset wins over flush and accept.
- With out_valid=0, data outputs hold their last value; consumers must qualify with out_valid.

## Configuration
- ALU_ISSUE_FWD_EN defined:
  - The ex_fwd_* ports exist.
  - If ex_fwd_wr && ex_fwd_rd!=0 && ex_fwd_rd==instr[19:15], ex_fwd_res replaces rs1_data before operand selection. Same rule for instr[24:20] and rs2_data.
  - Forwarding applies only where rs1/rs2 is actually used.
- Undefined: no ex_fwd_* ports; rs1_data/rs2_data are used directly.

## Structure
- Shared package rv32i_pkg holds:
  - alu_op_t enum with the codes above
  - opcode localparams (OP, OP_IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR, FENCE, SYSTEM)
  - funct7 constants F7_BASE/F7_ALT
- One combinational sub-module, alu_issue_dec: instr → alu_op, A/B selects, immediate, reg_write, alu_used, illegal. The top level holds the forwarding mux and the ID/EX register with its handshake.

## Test plan
- Reset: rst_n=0 for 2 cycles with in_valid=1 → out_valid=0 and all outputs 0. First accept after release appears on the next edge.
- sub x3,x1,x2 (0x402081B3), rs1=10, rs2=3 → alu_op=1000, alu_a=10, alu_b=3, rd=3, reg_write=1.
- srai x5,x6,4 (0x40435293) → alu_op=1101, alu_b=4. The same encoding with funct7=0100001 → illegal=1, reg_write=0.
- lui x7,0x12345 → alu_op=1001, alu_b=0x12345000. auipc at pc=0x100 with imm 1 → alu_a=0x100, alu_b=0x1000, op 0000.
- Back-pressure:
  - out_ready=0 for 3 cycles → in_ready=0 and outputs frozen.
  - out_ready=1 with in_valid=1 → new instruction issues with no bubble.
  - flush during a stall → out_valid=0 next cycle.
- With ALU_ISSUE_FWD_EN: ex_fwd_rd=1, ex_fwd_res=0xDEAD, add x2,x1,x1 → alu_a=alu_b=0xDEAD. With ex_fwd_rd=0 → no forwarding.
